// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair: one shift-add or
// restoring shift-subtract step per cycle, with sign fix-up on the final cycle.
module mdu_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div, neg_a, neg_b, b_zero;

    logic               issue, signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    assign issue     = start && (state == IDLE) && (op <= 3'd3);
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mag_b};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        quo = acc[WIDTH-1:0];
        rem = acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            {res_hi, res_lo} = (neg_a ^ neg_b) ? -acc : acc;
        end else begin
            // Divide by zero leaves |a| in the remainder, so re-signing it restores a.
            res_hi = neg_a ? -rem : rem;
            if (b_zero)
                res_lo = '1;
            else
                res_lo = (neg_a ^ neg_b) ? -quo : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (issue) begin
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        mag_b  <= abs_b;
                        is_div <= op[1];
                        neg_a  <= signed_op && a[WIDTH-1];
                        neg_b  <= signed_op && b[WIDTH-1];
                        b_zero <= (b == '0);
                        cnt    <= '0;
                    end else if (start && op == 3'd4) begin
                        hi <= a;
                    end else if (start && op == 3'd5) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
